// File: rtl/ctrl_cmd_decoder.sv
// ctrl_cmd_decoder: accepts framed WRITE/READ commands on an AXI4-Stream
// input, executes them against a 16 x 32 register file and returns a status
// header (plus read data for a good READ) on an AXI4-Stream output.
// Errored frames are drained to tlast and reported in a single header beat.
module ctrl_cmd_decoder #(
    parameter logic [7:0] MAGIC_IN  = 8'hA5,
    parameter logic [7:0] MAGIC_OUT = 8'h5A
) (
    input  logic        inner_clk,
    input  logic        rst_n,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready,
    output logic [7:0]  err_cnt
);

    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_READ   = 8'h02;
    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_MAGIC  = 8'h01;
    localparam logic [7:0] ST_OPCODE = 8'h02;
    localparam logic [7:0] ST_LENGTH = 8'h03;
    localparam logic [7:0] ST_RANGE  = 8'h04;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        DRAIN,
        RESP_HDR,
        RESP_DATA
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  status_q, status_d;
    logic [4:0]  idx_q, idx_d;       // payload index in WR_DATA, read index in RESP_DATA
    logic        rx_enable_q;        // holds s_tready low until the first edge after reset
    logic [31:0] m_tdata_d;
    logic        m_tvalid_d, m_tlast_d;
    logic [31:0] regfile [16];

    logic        s_fire, m_fire;
    logic        wr_en;
    logic [3:0]  word_addr;
    logic        last_word;
    logic        read_ok;
    logic [7:0]  hdr_op, hdr_addr, hdr_count, hdr_status;
    logic [8:0]  hdr_end;

    assign s_tready  = rx_enable_q &&
                       (state_q == IDLE || state_q == WR_DATA || state_q == DRAIN);
    assign s_fire    = s_tvalid && s_tready;
    assign m_fire    = m_tvalid && m_tready;
    assign word_addr = addr_q[3:0] + idx_q[3:0];
    assign last_word = ({3'b000, idx_q} == (count_q - 8'd1));
    assign read_ok   = (status_q == ST_OK) && (opcode_q == OP_READ);
    assign hdr_op    = s_tdata[23:16];
    assign hdr_addr  = s_tdata[15:8];
    assign hdr_count = s_tdata[7:0];

    // Classify an incoming header word in priority order.
    always_comb begin
        hdr_end = {1'b0, hdr_addr} + {1'b0, hdr_count};
        if (s_tdata[31:24] != MAGIC_IN)
            hdr_status = ST_MAGIC;
        else if (hdr_op != OP_WRITE && hdr_op != OP_READ)
            hdr_status = ST_OPCODE;
        else if (hdr_count == 8'd0 || hdr_end > 9'd16)
            hdr_status = ST_RANGE;
        else if ((hdr_op == OP_WRITE && s_tlast) || (hdr_op == OP_READ && !s_tlast))
            hdr_status = ST_LENGTH;
        else
            hdr_status = ST_OK;
    end

    // Next-state, frame bookkeeping and next registered response beat.
    always_comb begin
        // NOTE: every signal gets a default up front so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        opcode_d   = opcode_q;
        addr_d     = addr_q;
        count_d    = count_q;
        status_d   = status_q;
        idx_d      = idx_q;
        m_tdata_d  = m_tdata;
        m_tvalid_d = m_tvalid;
        m_tlast_d  = m_tlast;
        wr_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_fire) begin
                    opcode_d = hdr_op;
                    addr_d   = hdr_addr;
                    count_d  = hdr_count;
                    status_d = hdr_status;
                    idx_d    = '0;
                    if (hdr_status == ST_OK)
                        state_d = (hdr_op == OP_WRITE) ? WR_DATA : RESP_HDR;
                    else
                        state_d = s_tlast ? RESP_HDR : DRAIN;
                end
            end
            WR_DATA: begin
                if (s_fire) begin
                    wr_en = 1'b1;
                    idx_d = idx_q + 5'd1;
                    if (s_tlast) begin
                        status_d = last_word ? ST_OK : ST_LENGTH;
                        state_d  = RESP_HDR;
                    end else if (last_word) begin
                        status_d = ST_LENGTH;
                        state_d  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (s_fire && s_tlast)
                    state_d = RESP_HDR;
            end
            RESP_HDR: begin
                if (m_fire) begin
                    if (read_ok) begin
                        m_tdata_d = regfile[addr_q[3:0]];
                        m_tlast_d = (count_q == 8'd1);
                        idx_d     = 5'd1;
                        state_d   = RESP_DATA;
                    end else begin
                        m_tvalid_d = 1'b0;
                        m_tlast_d  = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            RESP_DATA: begin
                if (m_fire) begin
                    if (m_tlast) begin
                        m_tvalid_d = 1'b0;
                        m_tlast_d  = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        m_tdata_d = regfile[word_addr];
                        m_tlast_d = last_word;
                        idx_d     = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The response header is loaded on the same edge that enters RESP_HDR.
        if (state_q != RESP_HDR && state_d == RESP_HDR) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = {MAGIC_OUT, opcode_d, addr_d, status_d};
            m_tlast_d  = !((status_d == ST_OK) && (opcode_d == OP_READ));
        end
    end

    // Control state, frame fields and the error counter.
    always_ff @(posedge inner_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opcode_q    <= '0;
            addr_q      <= '0;
            count_q     <= '0;
            status_q    <= '0;
            idx_q       <= '0;
            rx_enable_q <= 1'b0;
            err_cnt     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            status_q    <= status_d;
            idx_q       <= idx_d;
            rx_enable_q <= 1'b1;
            if (state_q == RESP_HDR && m_fire && status_q != ST_OK && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

    // Registered response stream outputs.
    always_ff @(posedge inner_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else begin
            m_tdata  <= m_tdata_d;
            m_tvalid <= m_tvalid_d;
            m_tlast  <= m_tlast_d;
        end
    end

    // Register file: one write port driven by accepted WRITE payload words.
    always_ff @(posedge inner_clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array must read back as zero after reset, so it is
            // built from resettable flops rather than a RAM macro.
            for (int i = 0; i < 16; i++)
                regfile[i] <= '0;
        end else if (wr_en) begin
            regfile[word_addr] <= s_tdata;
        end
    end

endmodule

// File: tb/tb_ctrl_cmd_decoder.sv
// Self-checking bench for ctrl_cmd_decoder: reset state, a table of
// single-beat-response frames, directed multi-cycle sequences, and random
// frames compared with a frame-level reference model.
module tb_ctrl_cmd_decoder;

    logic        inner_clk;
    logic        rst_n;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic [7:0]  err_cnt;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] mregs [16];   // model register file
    int          merr;         // model error counter

    ctrl_cmd_decoder dut (
        .inner_clk (inner_clk),
        .rst_n     (rst_n),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .err_cnt   (err_cnt)
    );

    initial inner_clk = 1'b0;
    always #5 inner_clk = ~inner_clk;

    typedef struct {
        string       name;
        logic [31:0] hdr;
        int          n_pay;
        logic [32:0] want;     // {tlast, data} of the single response beat
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    endtask

    // Frame-level model: status from the header rules, writes limited to
    // min(payload words, N), and the full expected response beat list.
    function automatic void model_frame(input logic [31:0] fr [$], output logic [32:0] want [$]);
        logic [7:0] op, ad, n, st;
        int pay;
        op  = fr[0][23:16];
        ad  = fr[0][15:8];
        n   = fr[0][7:0];
        pay = fr.size() - 1;
        want = {};
        if (fr[0][31:24] != 8'hA5)                      st = 8'h01;
        else if (op != 8'h01 && op != 8'h02)            st = 8'h02;
        else if (n == 0 || int'(ad) + int'(n) > 16)     st = 8'h04;
        else if (op == 8'h01) begin
            for (int k = 0; k < pay && k < int'(n); k++) mregs[int'(ad) + k] = fr[k + 1];
            st = (pay == int'(n)) ? 8'h00 : 8'h03;
        end else
            st = (pay == 0) ? 8'h00 : 8'h03;
        want.push_back({!(st == 8'h00 && op == 8'h02), 8'h5A, op, ad, st});
        if (st == 8'h00 && op == 8'h02)
            for (int k = 0; k < int'(n); k++)
                want.push_back({k == int'(n) - 1, mregs[int'(ad) + k]});
        if (st != 8'h00 && merr < 255) merr++;
    endfunction

    // Present one word from a negedge; return at the negedge after acceptance.
    task automatic push_word(input logic [31:0] d, input logic last);
        int n;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = last;
        n = 0;
        while (!s_tready && n < 200) begin
            @(negedge inner_clk);
            n++;
        end
        check("s_tready_for_word", s_tready, 1);
        @(posedge inner_clk);
        @(negedge inner_clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Consume one response (up to its tlast beat). mode 0: ready high,
    // 1: toggle 1/0 starting at 1, 2: random.
    task automatic collect(input int mode, output logic [32:0] got [$], output int cycles,
                           output int unstable, output int busy_ready);
        logic        prev_stall;
        logic [31:0] pd;
        logic        pl;
        logic        done;
        got = {};
        cycles = 0; unstable = 0; busy_ready = 0;
        prev_stall = 1'b0; pd = '0; pl = 1'b0; done = 1'b0;
        while (!done && cycles < 400) begin
            if (prev_stall && (!m_tvalid || m_tdata !== pd || m_tlast !== pl)) unstable++;
            if (m_tvalid && s_tready) busy_ready++;
            case (mode)
                0:       m_tready = 1'b1;
                1:       m_tready = (cycles % 2 == 0);
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
            if (m_tvalid && m_tready) begin
                got.push_back({m_tlast, m_tdata});
                done = m_tlast;
            end
            prev_stall = m_tvalid && !m_tready;
            pd = m_tdata;
            pl = m_tlast;
            cycles++;
            @(posedge inner_clk);
            @(negedge inner_clk);
        end
        m_tready = 1'b0;
    endtask

    task automatic run_frame(input string name, input logic [31:0] fr [$], input int mode,
                             output logic [32:0] got [$], output int cycles);
        int u, b;
        for (int i = 0; i < fr.size(); i++) push_word(fr[i], i == fr.size() - 1);
        collect(mode, got, cycles, u, b);
        check({name, "_stall_stable"}, u, 0);
        check({name, "_sready_low_in_resp"}, b, 0);
    endtask

    task automatic compare_resp(input string name, input logic [32:0] got [$], input logic [32:0] want [$]);
        check({name, "_beats"}, got.size(), want.size());
        for (int i = 0; i < got.size() && i < want.size(); i++)
            check($sformatf("%s_beat%0d", name, i), got[i], want[i]);
    endtask

    task automatic model_and_run(input string name, input logic [31:0] fr [$], input int mode);
        logic [32:0] got [$];
        logic [32:0] want [$];
        int cyc;
        run_frame(name, fr, mode, got, cyc);
        model_frame(fr, want);
        compare_resp(name, got, want);
    endtask

    initial begin
        logic [31:0] fr [$];
        logic [32:0] got [$];
        logic [32:0] want [$];
        logic [32:0] exp_q [$];
        int          cyc, u, b, seen;
        logic [7:0]  op, ad, n;
        int          pay;

        vecs[0]  = '{"bad_magic",      32'hB401_0001, 1, {1'b1, 32'h5A01_0001}};
        vecs[1]  = '{"bad_opcode",     32'hA507_0201, 0, {1'b1, 32'h5A07_0202}};
        vecs[2]  = '{"range_wrap",     32'hA501_0F02, 2, {1'b1, 32'h5A01_0F04}};
        vecs[3]  = '{"count_zero",     32'hA502_0400, 0, {1'b1, 32'h5A02_0404}};
        vecs[4]  = '{"wr_hdr_tlast",   32'hA501_0001, 0, {1'b1, 32'h5A01_0003}};
        vecs[5]  = '{"rd_no_tlast",    32'hA502_0001, 1, {1'b1, 32'h5A02_0003}};
        vecs[6]  = '{"wr_ok_one",      32'hA501_0501, 1, {1'b1, 32'h5A01_0500}};
        vecs[7]  = '{"magic_over_op",  32'h00FF_FF00, 0, {1'b1, 32'h5AFF_FF01}};
        vecs[8]  = '{"op_over_range",  32'hA503_0F05, 0, {1'b1, 32'h5A03_0F02}};
        vecs[9]  = '{"end_at_16",      32'hA501_0E02, 2, {1'b1, 32'h5A01_0E00}};
        vecs[10] = '{"end_at_17",      32'hA501_0E03, 3, {1'b1, 32'h5A01_0E04}};

        for (int i = 0; i < 16; i++) mregs[i] = '0;
        merr = 0;

        // Reset state
        rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
        repeat (3) @(negedge inner_clk);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast",  m_tlast,  0);
        check("rst_m_tdata",  m_tdata,  0);
        check("rst_err_cnt",  err_cnt,  0);
        rst_n = 1'b1;
        @(posedge inner_clk);
        @(negedge inner_clk);
        check("s_tready_after_release", s_tready, 1);

        // WRITE two words then READ them back, with header latency check
        fr = '{32'hA501_0302, 32'h0000_0011, 32'h0000_0022};
        run_frame("wr31", fr, 0, got, cyc);
        model_frame(fr, want);
        exp_q = '{{1'b1, 32'h5A01_0300}};
        compare_resp("wr31", got, exp_q);
        push_word(32'hA502_0302, 1'b1);
        check("rd_hdr_valid_next_cycle", m_tvalid, 1);
        collect(0, got, cyc, u, b);
        fr = '{32'hA502_0302};
        model_frame(fr, want);
        exp_q = '{{1'b0, 32'h5A02_0300}, {1'b0, 32'h0000_0011}, {1'b1, 32'h0000_0022}};
        compare_resp("rd31", got, exp_q);
        check("rd31_back_to_back_cycles", cyc, 3);

        // Table of frames with a single response beat
        foreach (vecs[i]) begin
            fr = '{vecs[i].hdr};
            for (int k = 0; k < vecs[i].n_pay; k++) fr.push_back(32'hC0DE_0000 + k);
            run_frame(vecs[i].name, fr, 0, got, cyc);
            check({vecs[i].name, "_beats"}, got.size(), 1);
            if (got.size() > 0) check({vecs[i].name, "_resp"}, got[0], vecs[i].want);
            model_frame(fr, want);
            check({vecs[i].name, "_err_cnt"}, err_cnt, 8'(merr));
        end

        // Short write (tlast early) and long write (extra word drained)
        fr = '{32'hA501_0803, 32'hAAAA_0001, 32'hAAAA_0002};
        run_frame("wr_short", fr, 0, got, cyc);
        model_frame(fr, want);
        exp_q = '{{1'b1, 32'h5A01_0803}};
        compare_resp("wr_short", got, exp_q);
        fr = '{32'hA501_0A02, 32'hBBBB_0001, 32'hBBBB_0002, 32'hBBBB_0003};
        run_frame("wr_long", fr, 0, got, cyc);
        model_frame(fr, want);
        exp_q = '{{1'b1, 32'h5A01_0A03}};
        compare_resp("wr_long", got, exp_q);
        fr = '{32'hA502_0805};
        model_and_run("rd_partial", fr, 0);

        // Random frames against the model
        for (int t = 0; t < 40; t++) begin
            op = ($urandom_range(0, 9) < 5) ? 8'h01 :
                 ($urandom_range(0, 3) != 0) ? 8'h02 : 8'($urandom_range(3, 255));
            ad = 8'($urandom_range(0, 17));
            n  = 8'($urandom_range(0, 6));
            if (op == 8'h01) pay = ($urandom_range(0, 3) != 0) ? int'(n) : $urandom_range(0, int'(n) + 2);
            else             pay = ($urandom_range(0, 3) != 0) ? 0 : $urandom_range(1, 2);
            fr = '{{($urandom_range(0, 9) == 0) ? 8'h3C : 8'hA5, op, ad, n}};
            for (int k = 0; k < pay; k++) fr.push_back($urandom);
            model_and_run($sformatf("rand%0d", t), fr, 2);
        end
        check("rand_err_cnt", err_cnt, 8'(merr));

        // Full READ with m_tready toggling every cycle
        fr = '{32'hA502_0010};
        run_frame("rd16_toggle", fr, 1, got, cyc);
        model_frame(fr, want);
        compare_resp("rd16_toggle", got, want);

        // Reset in the middle of a response aborts it and clears the file
        push_word(32'hA502_0010, 1'b1);
        m_tready = 1'b1;
        repeat (3) @(posedge inner_clk);
        @(negedge inner_clk);
        rst_n = 1'b0;
        #1;
        check("abort_m_tvalid", m_tvalid, 0);
        check("abort_m_tdata",  m_tdata,  0);
        check("abort_s_tready", s_tready, 0);
        check("abort_err_cnt",  err_cnt,  0);
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        merr = 0;
        @(negedge inner_clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge inner_clk);
            if (m_tvalid) seen++;
        end
        m_tready = 1'b0;
        check("abort_no_partial_resp", seen, 0);
        fr = '{32'hA502_0010};
        model_and_run("rd_after_reset", fr, 0);

        // Error counter saturation
        fr = '{32'h1101_0001};
        for (int t = 0; t < 260; t++) begin
            run_frame("bad_burst", fr, 0, got, cyc);
            model_frame(fr, want);
            if (t == 254) check("err_cnt_at_255_frames", err_cnt, 8'd255);
        end
        compare_resp("bad_burst_last", got, want);
        check("err_cnt_saturated", err_cnt, 8'd255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
